// File: rtl/seq_pkg.sv
// Shared types and constants for the tempo-driven step sequencer.
package seq_pkg;

  typedef enum logic [1:0] {
    StIdle,
    StRun,
    StPause
  } seq_state_e;

  localparam int unsigned CNT_W  = 9;
  localparam int unsigned NBANDS = 10;

  // Lower edge of each tempo band; tempo must be strictly above to enter the band.
  localparam logic [9:0] BAND_THRESH [NBANDS-1] = '{
    10'd100, 10'd200, 10'd300, 10'd400, 10'd500,
    10'd600, 10'd700, 10'd800, 10'd900
  };

  // Step period in clock cycles, slowest band last.
  localparam logic [CNT_W-1:0] BAND_PERIOD [NBANDS] = '{
    9'd10, 9'd25, 9'd50, 9'd100, 9'd150,
    9'd200, 9'd250, 9'd300, 9'd350, 9'd400
  };

  localparam logic [CNT_W-1:0] PERIOD_RST = 9'd10;

endpackage

// File: rtl/seq_tempo_lut.sv
// Combinational tempo quantiser: raw 10-bit tempo control to step period in cycles.
module seq_tempo_lut
  import seq_pkg::*;
(
  input  logic [9:0]       tempo,
  output logic [CNT_W-1:0] period
);

  // Ascending scan so the highest band whose threshold is exceeded wins.
  always_comb begin
    period = BAND_PERIOD[0];
    for (int i = 0; i < int'(NBANDS) - 1; i++) begin
      if (tempo > BAND_THRESH[i]) period = BAND_PERIOD[i+1];
    end
  end

endmodule

// File: rtl/seq_step_scheduler.sv
// Step-sequencer controller: walks an NSTEPS pattern at a quantised tempo and drives
// note, 50% gate and a step pulse. Tempo is re-latched only at step boundaries.
module seq_step_scheduler
  import seq_pkg::*;
#(
  parameter int unsigned NSTEPS = 8,
  parameter int unsigned NOTE_W = 7,
  parameter int unsigned LOOP   = 1
) (
  input  logic                       clk100hz,
  input  logic                       reset,
  input  logic [9:0]                 tempo_in,
  input  logic                       start,
  input  logic                       stop,
  input  logic                       pause,
  input  logic [NSTEPS-1:0]          step_en,
  input  logic [NSTEPS*NOTE_W-1:0]   notes_in,
  output logic [NOTE_W-1:0]          note_out,
  output logic                       gate,
  output logic                       step_tick,
  output logic [$clog2(NSTEPS)-1:0]  step_idx,
  output logic                       running
);

  localparam int unsigned IDX_W = $clog2(NSTEPS);

  seq_state_e        state_q, state_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic [CNT_W-1:0]  period_q, period_d;
  logic [IDX_W-1:0]  idx_q, idx_d;
  logic [NOTE_W-1:0] note_q, note_d;
  logic              gate_q, gate_d;
  logic              tick_q, tick_d;
  logic              running_q, running_d;

  logic [CNT_W-1:0]  lut_period;
  logic [CNT_W-1:0]  lut_hp;
  logic [CNT_W-1:0]  hp;
  logic [CNT_W-1:0]  cnt_inc;
  logic [IDX_W-1:0]  idx_inc;
  logic [NOTE_W-1:0] note_inc;

  seq_tempo_lut u_tempo_lut (
    .tempo  (tempo_in),
    .period (lut_period)
  );

  assign lut_hp  = lut_period >> 1;
  assign hp      = period_q >> 1;
  assign cnt_inc = cnt_q + CNT_W'(1);
  assign idx_inc = idx_q + IDX_W'(1);

  // Note of the step that follows the current one (wraps naturally, NSTEPS is a power of two).
  always_comb begin
    note_inc = notes_in[NOTE_W-1:0];
    for (int k = 0; k < int'(NSTEPS); k++) begin
      if (idx_inc == IDX_W'(k)) note_inc = notes_in[k*NOTE_W +: NOTE_W];
    end
  end

  // Next-state and registered-output logic; priority stop > pause > start.
  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    period_d  = period_q;
    idx_d     = idx_q;
    note_d    = note_q;
    gate_d    = gate_q;
    tick_d    = 1'b0;
    running_d = running_q;

    if (stop) begin
      state_d   = StIdle;
      cnt_d     = '0;
      idx_d     = '0;
      gate_d    = 1'b0;
      running_d = 1'b0;
    end else begin
      unique case (state_q)
        StIdle: begin
          if (!pause && start) begin
            state_d   = StRun;
            cnt_d     = '0;
            idx_d     = '0;
            period_d  = lut_period;
            note_d    = notes_in[NOTE_W-1:0];
            gate_d    = step_en[0] && (lut_hp != '0);
            tick_d    = 1'b1;
            running_d = 1'b1;
          end
        end
        StRun: begin
          if (pause) begin
            state_d   = StPause;
            gate_d    = 1'b0;
            running_d = 1'b0;
          end else if (cnt_q == period_q - CNT_W'(1)) begin
            if ((LOOP == 0) && (idx_q == IDX_W'(NSTEPS - 1))) begin
              state_d   = StIdle;
              cnt_d     = '0;
              idx_d     = '0;
              gate_d    = 1'b0;
              running_d = 1'b0;
            end else begin
              cnt_d    = '0;
              idx_d    = idx_inc;
              period_d = lut_period;
              note_d   = note_inc;
              gate_d   = step_en[idx_inc] && (lut_hp != '0);
              tick_d   = 1'b1;
            end
          end else begin
            cnt_d  = cnt_inc;
            gate_d = step_en[idx_q] && (cnt_inc < hp);
          end
        end
        StPause: begin
          // Resume at the frozen count; no step pulse since the step already started.
          if (!pause && start) begin
            state_d   = StRun;
            gate_d    = step_en[idx_q] && (cnt_q < hp);
            running_d = 1'b1;
          end
        end
        default: begin
          state_d = StIdle;
        end
      endcase
    end
  end

  // State and output registers with synchronous reset.
  always_ff @(posedge clk100hz) begin
    if (reset) begin
      state_q   <= StIdle;
      cnt_q     <= '0;
      period_q  <= PERIOD_RST;
      idx_q     <= '0;
      note_q    <= '0;
      gate_q    <= 1'b0;
      tick_q    <= 1'b0;
      running_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      period_q  <= period_d;
      idx_q     <= idx_d;
      note_q    <= note_d;
      gate_q    <= gate_d;
      tick_q    <= tick_d;
      running_q <= running_d;
    end
  end

  assign note_out  = note_q;
  assign gate      = gate_q;
  assign step_tick = tick_q;
  assign step_idx  = idx_q;
  assign running   = running_q;

endmodule

// File: tb/tb_seq_step_scheduler.sv
// Scoreboard bench for seq_step_scheduler: per-cycle expected outputs are queued as
// stimulus is planned and popped against the DUT one cycle at a time.
module tb_seq_step_scheduler;

  typedef struct packed {
    logic       tick;
    logic       gate;
    logic       run;
    logic [2:0] idx;
    logic [6:0] note;
  } obs_t;

  logic        clk100hz = 1'b0;
  logic        reset;
  logic [9:0]  tempo_in;
  logic        start, stop, pause;
  logic [7:0]  step_en;
  logic [55:0] notes_in;

  logic [6:0] note0, note1;
  logic       gate0, gate1, tick0, tick1, run0, run1;
  logic [2:0] idx0, idx1;

  int total = 0;
  int bad   = 0;
  obs_t exp_q[$];
  int   per_q[$];

  always #5 clk100hz = ~clk100hz;

  seq_step_scheduler #(.NSTEPS(8), .NOTE_W(7), .LOOP(1)) dut0 (
    .clk100hz (clk100hz), .reset (reset), .tempo_in (tempo_in), .start (start),
    .stop (stop), .pause (pause), .step_en (step_en), .notes_in (notes_in),
    .note_out (note0), .gate (gate0), .step_tick (tick0), .step_idx (idx0), .running (run0)
  );

  seq_step_scheduler #(.NSTEPS(8), .NOTE_W(7), .LOOP(0)) dut1 (
    .clk100hz (clk100hz), .reset (reset), .tempo_in (tempo_in), .start (start),
    .stop (stop), .pause (pause), .step_en (step_en), .notes_in (notes_in),
    .note_out (note1), .gate (gate1), .step_tick (tick1), .step_idx (idx1), .running (run1)
  );

  task automatic cyc();
    @(posedge clk100hz);
    #1;
  endtask

  function automatic obs_t mk(input logic tk, input logic gt, input logic rn, input int s,
                              input int nt);
    obs_t e;
    e.tick = tk;
    e.gate = gt;
    e.run  = rn;
    e.idx  = 3'(s);
    e.note = 7'(nt);
    return e;
  endfunction

  // Queue cycles c0..c1-1 of step s (note 60+s), gate high for the first per/2 cycles.
  task automatic push_step(input int s, input int c0, input int c1, input int per,
                           input logic en, input logic tk);
    for (int c = c0; c < c1; c++) exp_q.push_back(mk(tk && (c == c0), en && (c < per / 2),
                                                     1'b1, s, 60 + s));
  endtask

  task automatic push_const(input obs_t e, input int n);
    for (int i = 0; i < n; i++) exp_q.push_back(e);
  endtask

  function automatic int exp_period(input int t);
    if (t > 900) return 400;
    else if (t > 800) return 350;
    else if (t > 700) return 300;
    else if (t > 600) return 250;
    else if (t > 500) return 200;
    else if (t > 400) return 150;
    else if (t > 300) return 100;
    else if (t > 200) return 50;
    else if (t > 100) return 25;
    return 10;
  endfunction

  task automatic go_idle();
    stop = 1'b1; start = 1'b0; pause = 1'b0;
    cyc();
    stop = 1'b0;
  endtask

  task automatic test_reset();
    obs_t o0, o1;
    reset = 1'b1;
    cyc(); cyc();
    reset = 1'b0;
    o0 = {tick0, gate0, run0, idx0, note0};
    o1 = {tick1, gate1, run1, idx1, note1};
    total++;
    if (o0 !== mk(0, 0, 0, 0, 0)) begin bad++; $display("FAIL reset_loop got=%h want=%h", o0, mk(0, 0, 0, 0, 0)); end
    total++;
    if (o1 !== mk(0, 0, 0, 0, 0)) begin bad++; $display("FAIL reset_oneshot got=%h want=%h", o1, mk(0, 0, 0, 0, 0)); end
    cyc(); cyc();
    o0 = {tick0, gate0, run0, idx0, note0};
    total++;
    if (o0 !== mk(0, 0, 0, 0, 0)) begin bad++; $display("FAIL idle_hold got=%h want=%h", o0, mk(0, 0, 0, 0, 0)); end
  endtask

  task automatic test_basic();
    obs_t e, o;
    step_en = 8'hFF; tempo_in = 10'd50;
    for (int s = 0; s < 9; s++) push_step(s % 8, 0, 10, 10, 1'b1, 1'b1);
    exp_q[80].note = 7'd60;
    for (int s = 80; s < 90; s++) begin exp_q[s].idx = 3'd0; exp_q[s].note = 7'd60; end
    start = 1'b1;
    for (int i = 0; exp_q.size() > 0; i++) begin
      cyc();
      e = exp_q.pop_front();
      o = {tick0, gate0, run0, idx0, note0};
      total++;
      if (o !== e) begin bad++; $display("FAIL basic cyc=%0d got=%h want=%h", i, o, e); end
      if (i == 0) start = 1'b0;
    end
    stop = 1'b1;
    cyc();
    stop = 1'b0;
    o = {tick0, gate0, run0, idx0, note0};
    total++;
    if (o !== mk(0, 0, 0, 0, 60)) begin bad++; $display("FAIL basic_stop got=%h want=%h", o, mk(0, 0, 0, 0, 60)); end
  endtask

  task automatic test_mask();
    obs_t e, o;
    step_en = 8'b0000_0101; tempo_in = 10'd250;
    for (int s = 0; s < 8; s++) push_step(s, 0, 50, 50, step_en[s], 1'b1);
    start = 1'b1;
    for (int i = 0; exp_q.size() > 0; i++) begin
      cyc();
      e = exp_q.pop_front();
      o = {tick0, gate0, run0, idx0, note0};
      total++;
      if (o !== e) begin bad++; $display("FAIL mask cyc=%0d got=%h want=%h", i, o, e); end
      if (i == 0) start = 1'b0;
    end
    go_idle();
    step_en = 8'hFF;
  endtask

  task automatic test_bands();
    int vals[13] = '{0, 100, 101, 200, 201, 250, 400, 401, 700, 701, 900, 901, 1023};
    int n, g, want;
    step_en = 8'hFF;
    foreach (vals[j]) begin
      go_idle();
      tempo_in = 10'(vals[j]);
      per_q.push_back(exp_period(vals[j]));
      start = 1'b1;
      cyc();
      start = 1'b0;
      total++;
      if (tick0 !== 1'b1) begin bad++; $display("FAIL band_start tempo=%0d got=%b want=1", vals[j], tick0); end
      n = 1; g = (gate0 === 1'b1) ? 1 : 0;
      for (int k = 0; k < 500; k++) begin
        cyc();
        if (tick0 === 1'b1) break;
        n++;
        if (gate0 === 1'b1) g++;
      end
      want = per_q.pop_front();
      total++;
      if (n != want) begin bad++; $display("FAIL band_period tempo=%0d got=%0d want=%0d", vals[j], n, want); end
      total++;
      if (g != want / 2) begin bad++; $display("FAIL band_gate tempo=%0d got=%0d want=%0d", vals[j], g, want / 2); end
    end
    go_idle();
  endtask

  task automatic test_tempo_change();
    obs_t e, o;
    step_en = 8'hFF; tempo_in = 10'd50;
    push_step(0, 0, 10, 10, 1'b1, 1'b1);
    push_step(1, 0, 400, 400, 1'b1, 1'b1);
    start = 1'b1;
    for (int i = 0; exp_q.size() > 0; i++) begin
      cyc();
      e = exp_q.pop_front();
      o = {tick0, gate0, run0, idx0, note0};
      total++;
      if (o !== e) begin bad++; $display("FAIL tempo_change cyc=%0d got=%h want=%h", i, o, e); end
      if (i == 0) start = 1'b0;
      if (i == 3) tempo_in = 10'd950;
    end
    go_idle();
    tempo_in = 10'd50;
  endtask

  task automatic test_pause();
    obs_t e, o;
    step_en = 8'hFF; tempo_in = 10'd50;
    push_step(0, 0, 10, 10, 1'b1, 1'b1);
    push_step(1, 0, 10, 10, 1'b1, 1'b1);
    push_step(2, 0, 8, 10, 1'b1, 1'b1);
    push_const(mk(0, 0, 0, 2, 62), 30);
    push_step(2, 7, 10, 10, 1'b1, 1'b0);
    push_step(3, 0, 10, 10, 1'b1, 1'b1);
    push_step(4, 0, 2, 10, 1'b1, 1'b1);
    push_const(mk(0, 0, 0, 4, 64), 3);
    push_step(4, 1, 10, 10, 1'b1, 1'b0);
    start = 1'b1;
    for (int i = 0; exp_q.size() > 0; i++) begin
      cyc();
      e = exp_q.pop_front();
      o = {tick0, gate0, run0, idx0, note0};
      total++;
      if (o !== e) begin bad++; $display("FAIL pause cyc=%0d got=%h want=%h", i, o, e); end
      if (i == 0) start = 1'b0;
      if (i == 27) pause = 1'b1;
      if (i == 40) start = 1'b1;
      if (i == 57) pause = 1'b0;
      if (i == 72) pause = 1'b1;
      if (i == 75) pause = 1'b0;
    end
    go_idle();
  endtask

  task automatic test_priority();
    obs_t e, o;
    step_en = 8'hFF; tempo_in = 10'd50;
    push_step(0, 0, 5, 10, 1'b1, 1'b1);
    push_const(mk(0, 0, 0, 0, 60), 2);
    start = 1'b1;
    for (int i = 0; exp_q.size() > 0; i++) begin
      cyc();
      e = exp_q.pop_front();
      o = {tick0, gate0, run0, idx0, note0};
      total++;
      if (o !== e) begin bad++; $display("FAIL prio_stop cyc=%0d got=%h want=%h", i, o, e); end
      if (i == 0) start = 1'b0;
      if (i == 4) begin stop = 1'b1; pause = 1'b1; start = 1'b1; end
      if (i == 6) begin stop = 1'b0; pause = 1'b0; start = 1'b0; end
    end
    for (int s = 0; s < 5; s++) push_step(s, 0, 10, 10, 1'b1, 1'b1);
    push_step(5, 0, 5, 10, 1'b1, 1'b1);
    push_const(mk(0, 0, 0, 0, 0), 2);
    start = 1'b1;
    for (int i = 0; exp_q.size() > 0; i++) begin
      cyc();
      e = exp_q.pop_front();
      o = {tick0, gate0, run0, idx0, note0};
      total++;
      if (o !== e) begin bad++; $display("FAIL prio_reset cyc=%0d got=%h want=%h", i, o, e); end
      if (i == 0) start = 1'b0;
      if (i == 54) begin reset = 1'b1; start = 1'b1; end
      if (i == 55) begin reset = 1'b0; start = 1'b0; end
    end
  endtask

  task automatic test_oneshot();
    obs_t e, o;
    int ticks;
    go_idle();
    step_en = 8'hFF; tempo_in = 10'd150;
    for (int s = 0; s < 8; s++) push_step(s, 0, 25, 25, 1'b1, 1'b1);
    push_const(mk(0, 0, 0, 0, 67), 31);
    ticks = 0;
    start = 1'b1;
    for (int i = 0; exp_q.size() > 0; i++) begin
      cyc();
      e = exp_q.pop_front();
      o = {tick1, gate1, run1, idx1, note1};
      if (tick1 === 1'b1) ticks++;
      total++;
      if (o !== e) begin bad++; $display("FAIL oneshot cyc=%0d got=%h want=%h", i, o, e); end
      if (i == 0) start = 1'b0;
    end
    total++;
    if (ticks != 8) begin bad++; $display("FAIL oneshot_ticks got=%0d want=8", ticks); end
  endtask

  initial begin
    reset = 1'b1; tempo_in = 10'd50; start = 1'b0; stop = 1'b0; pause = 1'b0;
    step_en = 8'hFF;
    for (int k = 0; k < 8; k++) notes_in[k*7 +: 7] = 7'(60 + k);
    test_reset();
    test_basic();
    test_mask();
    test_bands();
    test_tempo_change();
    test_pause();
    test_priority();
    test_oneshot();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog expired total=%0d bad=%0d", total, bad);
    $fatal(1, "watchdog");
  end

endmodule
